spi_alu_slave_frame: RTL and testbench

Parametrised SPI-style slave that receives a framed ALU request (two operands plus opcode) from the Arduino master, executes it in one cycle, and shifts the result back on MISO. It generalises the fixed 4-bit receive-only slave with configurable widths, a full ALU opcode set, result transmission, and frame/opcode error reporting. It sits between the Arduino SPI pins and the board LEDs.

---
 rtl/spi_alu_slave_frame_if.sv | 10 +
 rtl/spi_alu_slave_frame.sv | 178 +++++++++++++++++
 tb/tb_spi_alu_slave_frame.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_alu_slave_frame_if.sv
// SPI pin bundle between the Arduino master and the ALU slave.
// The master drives chip select and MOSI; the slave returns MISO.
interface spi_alu_slave_frame_if;
    logic CS;
    logic MOSI;
    logic MISO;

    modport master (output CS, output MOSI, input MISO);
    modport slave  (input CS, input MOSI, output MISO);
endinterface

// File: rtl/spi_alu_slave_frame.sv
// Framed SPI ALU slave: receives start bit + op1/op2/opcode, executes in one cycle,
// then shifts the result back MSB first on MISO while holding it on result/leds.
module spi_alu_slave_frame #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned LED_W  = 4
) (
    input  logic                  clk_arduino,
    input  logic                  reset,
    spi_alu_slave_frame_if.slave  spi,
    output logic [LED_W-1:0]      leds,
    output logic [2*OP_W-1:0]     result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  op_err
);

    localparam int unsigned FRAME_W = 2 * OP_W + CODE_W;
    localparam int unsigned RES_W   = 2 * OP_W;
    localparam int unsigned RX_CW   = $clog2(FRAME_W);
    localparam int unsigned TX_CW   = $clog2(RES_W);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRx   = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StTx   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
    logic [RX_CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [TX_CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [RES_W-1:0]   tx_sh_q, tx_sh_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               op_err_q, op_err_d;
    logic               miso_q, miso_d;

    logic [RES_W-1:0]  op1_ext, op2_ext, alu_res;
    logic [CODE_W-1:0] opc;
    logic              alu_undef;

    // Frame is shifted in MSB first: op1 ends up in the top bits, opcode at the bottom.
    always_comb begin
        op1_ext   = RES_W'(rx_sh_q[FRAME_W-1 -: OP_W]);
        op2_ext   = RES_W'(rx_sh_q[CODE_W +: OP_W]);
        opc       = rx_sh_q[CODE_W-1:0];
        alu_undef = 1'b0;
        case (opc)
            CODE_W'(0): alu_res = op1_ext + op2_ext;
            CODE_W'(1): alu_res = op1_ext - op2_ext;
            CODE_W'(2): alu_res = op1_ext & op2_ext;
            CODE_W'(3): alu_res = op1_ext | op2_ext;
            CODE_W'(4): alu_res = op1_ext ^ op2_ext;
            CODE_W'(5): alu_res = op1_ext * op2_ext;
            CODE_W'(6): alu_res = op1_ext << op2_ext;
            CODE_W'(7): alu_res = op1_ext >> op2_ext;
            default: begin
                alu_res   = '0;
                alu_undef = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        rx_sh_d        = rx_sh_q;
        rx_cnt_d       = rx_cnt_q;
        tx_cnt_d       = tx_cnt_q;
        tx_sh_d        = tx_sh_q;
        result_d       = result_q;
        leds_d         = leds_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        op_err_d       = op_err_q;
        miso_d         = miso_q;

        case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (!spi.CS && spi.MOSI) begin
                    state_d  = StRx;
                    rx_cnt_d = '0;
                    miso_d   = 1'b1;
                end
            end
            StRx: begin
                if (spi.CS) begin
                    state_d     = StIdle;
                    miso_d      = 1'b0;
                    frame_err_d = 1'b1;
                    rx_cnt_d    = '0;
                end else begin
                    rx_sh_d = {rx_sh_q[FRAME_W-2:0], spi.MOSI};
                    miso_d  = 1'b1;
                    if (rx_cnt_q == RX_CW'(FRAME_W - 1)) begin
                        state_d  = StExec;
                        rx_cnt_d = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            StExec: begin
                if (spi.CS) begin
                    state_d     = StIdle;
                    miso_d      = 1'b0;
                    frame_err_d = 1'b1;
                end else begin
                    result_d       = alu_res;
                    leds_d         = alu_res[LED_W-1:0];
                    result_valid_d = 1'b1;
                    op_err_d       = alu_undef;
                    miso_d         = alu_res[RES_W-1];
                    tx_sh_d        = alu_res << 1;
                    tx_cnt_d       = '0;
                    state_d        = StTx;
                end
            end
            StTx: begin
                if (spi.CS || tx_cnt_q == TX_CW'(RES_W - 1)) begin
                    state_d  = StIdle;
                    miso_d   = 1'b0;
                    tx_cnt_d = '0;
                end else begin
                    miso_d   = tx_sh_q[RES_W-1];
                    tx_sh_d  = tx_sh_q << 1;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_arduino or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            rx_sh_q        <= '0;
            rx_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            tx_sh_q        <= '0;
            result_q       <= '0;
            leds_q         <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            op_err_q       <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_sh_q        <= rx_sh_d;
            rx_cnt_q       <= rx_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_sh_q        <= tx_sh_d;
            result_q       <= result_d;
            leds_q         <= leds_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            frame_err_q    <= frame_err_d;
            op_err_q       <= op_err_d;
            miso_q         <= miso_d;
        end
    end

    assign spi.MISO     = miso_q;
    assign leds         = leds_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign frame_err    = frame_err_q;
    assign op_err       = op_err_q;

endmodule

// File: tb/tb_spi_alu_slave_frame.sv
// Bench for spi_alu_slave_frame: default 4-bit instance plus an 8-bit operand instance,
// random and directed frames checked against an arithmetic ALU model.
module tb_spi_alu_slave_frame;

    logic clk;
    logic rst_n;
    bit   sel;
    int   checks;
    int   failures;

    spi_alu_slave_frame_if if4 ();
    spi_alu_slave_frame_if if8 ();

    logic [3:0]  leds4;
    logic [7:0]  res4;
    logic        rv4, busy4, fe4, oe4;
    logic [7:0]  leds8;
    logic [15:0] res8;
    logic        rv8, busy8, fe8, oe8;

    spi_alu_slave_frame #(.OP_W(4), .CODE_W(4), .LED_W(4)) dut4 (
        .clk_arduino  (clk),
        .reset        (rst_n),
        .spi          (if4.slave),
        .leds         (leds4),
        .result       (res4),
        .result_valid (rv4),
        .busy         (busy4),
        .frame_err    (fe4),
        .op_err       (oe4)
    );

    spi_alu_slave_frame #(.OP_W(8), .CODE_W(4), .LED_W(8)) dut8 (
        .clk_arduino  (clk),
        .reset        (rst_n),
        .spi          (if8.slave),
        .leds         (leds8),
        .result       (res8),
        .result_valid (rv8),
        .busy         (busy8),
        .frame_err    (fe8),
        .op_err       (oe8)
    );

    logic [15:0] o_res;
    logic [7:0]  o_leds;
    logic        o_miso, o_rv, o_busy, o_fe, o_oe;
    assign o_res  = sel ? res8  : {8'h00, res4};
    assign o_leds = sel ? leds8 : {4'h0, leds4};
    assign o_miso = sel ? if8.MISO : if4.MISO;
    assign o_rv   = sel ? rv8   : rv4;
    assign o_busy = sel ? busy8 : busy4;
    assign o_fe   = sel ? fe8   : fe4;
    assign o_oe   = sel ? oe8   : oe4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic cs, input logic mosi);
        if (s) begin
            if8.CS = cs; if8.MOSI = mosi;
        end else begin
            if4.CS = cs; if4.MOSI = mosi;
        end
    endtask

    function automatic logic [31:0] alu_model(input longint unsigned a, input longint unsigned b,
                                              input int unsigned opc, input int unsigned resw,
                                              output bit undef);
        longint unsigned m, r;
        m = (64'd1 << resw) - 1;
        undef = 1'b0;
        case (opc)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * b;
            6: r = (b >= resw) ? 0 : (a << b);
            7: r = (b >= resw) ? 0 : (a >> b);
            default: begin r = 0; undef = 1'b1; end
        endcase
        return 32'(r & m);
    endfunction

    // One complete transaction with `lead` ignored zero bits before the start bit.
    task automatic run_frame(input bit s, input int unsigned a, input int unsigned b,
                             input int unsigned opc, input int lead);
        int unsigned     ow, resw, fw;
        logic [31:0]     exp, ledmask, miso_seq, prev_oe;
        longint unsigned frame;
        bit              undef;
        bit              ack_ok;
        int              busy_cnt, rv_cnt;
        ow      = s ? 8 : 4;
        resw    = 2 * ow;
        fw      = 2 * ow + 4;
        ledmask = s ? 32'hFF : 32'hF;
        exp     = alu_model(a, b, opc, resw, undef);
        frame   = (longint'(a) << (ow + 4)) | (longint'(b) << 4) | longint'(opc);
        sel     = s;
        prev_oe = 32'(o_oe);
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            drive(s, 1'b0, 1'b0);
        end
        @(negedge clk);
        if (lead > 0) check("lead_zero_idle", 32'(o_busy), 32'd0);
        drive(s, 1'b0, 1'b1);
        busy_cnt = 0;
        ack_ok   = 1'b1;
        for (int i = int'(fw) - 1; i >= 0; i--) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_miso !== 1'b1 || o_rv !== 1'b0) ack_ok = 1'b0;
            drive(s, 1'b0, frame[i]);
        end
        @(negedge clk);
        if (o_busy) busy_cnt++;
        if (o_miso !== 1'b1 || o_rv !== 1'b0) ack_ok = 1'b0;
        check("rx_ack", 32'(ack_ok), 32'd1);
        check("op_err_sticky", 32'(o_oe), prev_oe);
        @(negedge clk);
        if (o_busy) busy_cnt++;
        check("result", 32'(o_res), exp);
        check("leds", 32'(o_leds), exp & ledmask);
        check("result_valid", 32'(o_rv), 32'd1);
        check("op_err", 32'(o_oe), 32'(undef));
        miso_seq = 32'(o_miso);
        rv_cnt   = 0;
        for (int k = 1; k < int'(resw); k++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_rv) rv_cnt++;
            miso_seq = (miso_seq << 1) | 32'(o_miso);
        end
        check("miso_seq", miso_seq, exp);
        check("rv_single_pulse", 32'(rv_cnt), 32'd0);
        @(negedge clk);
        check("idle_miso", 32'(o_miso), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("busy_len", 32'(busy_cnt), fw + resw + 1);
        check("result_hold", 32'(o_res), exp);
        drive(s, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] prev_res, prev_leds;
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        rst_n    = 1'b0;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_state", {o_res, o_leds, o_miso, o_rv, o_busy, o_fe, o_oe}, 32'd0);
        rst_n = 1'b1;

        run_frame(0, 3, 5, 0, 0);
        run_frame(0, 3, 5, 1, 2);
        run_frame(0, 7, 9, 5, 0);
        run_frame(0, 15, 4, 6, 1);
        run_frame(0, 12, 9, 7, 0);
        run_frame(0, 1, 2, 15, 0);
        run_frame(0, 2, 2, 0, 0);

        // Abort after six data bits.
        prev_res  = 32'(o_res);
        prev_leds = 32'(o_leds);
        @(negedge clk); drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(0, 1'b0, 1'($urandom_range(0, 1)));
        end
        @(negedge clk); drive(0, 1'b1, 1'b0);
        @(negedge clk);
        check("abort_frame_err", 32'(o_fe), 32'd1);
        check("abort_miso", 32'(o_miso), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_result", 32'(o_res), prev_res);
        check("abort_leds", 32'(o_leds), prev_leds);
        @(negedge clk);
        check("abort_pulse_end", 32'(o_fe), 32'd0);
        run_frame(0, 6, 7, 0, 0);

        for (int n = 0; n < 20; n++)
            run_frame(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      int'($urandom_range(0, 2)));

        // Reset asserted mid-TX after an OR that leaves a nonzero result.
        @(negedge clk); drive(0, 1'b0, 1'b1);
        begin
            logic [11:0] fr;
            fr = 12'hA53;
            for (int i = 11; i >= 0; i--) begin
                @(negedge clk); drive(0, 1'b0, fr[i]);
            end
        end
        repeat (4) @(negedge clk);
        check("pre_reset_result", 32'(o_res), 32'h0F);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_tx", {o_res, o_leds, o_miso, o_rv, o_busy, o_fe, o_oe}, 32'd0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0);
        rst_n = 1'b1;
        run_frame(0, 9, 4, 2, 3);

        run_frame(1, 200, 200, 5, 0);
        for (int n = 0; n < 4; n++)
            run_frame(1, $urandom_range(0, 255), $urandom_range(0, 20), $urandom_range(0, 9), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
